// File: rtl/fu_pkg.sv
// Shared constants, FU type encoding and the per-FU type map for the FU allocator.
package fu_pkg;

  localparam int NUM_FU  = 3;
  localparam int TAG_W   = 6;
  localparam int CNT_W   = 3;
  localparam int ALU_LAT = 1;
  localparam int MEM_LAT = 3;

  localparam int FU_ALU0 = 0;
  localparam int FU_ALU1 = 1;
  localparam int FU_MEM0 = 2;

  typedef enum logic {
    FU_ALU = 1'b0,
    FU_MEM = 1'b1
  } fu_type_e;

  function automatic fu_type_e fu_type_of(input int idx);
    case (idx)
      FU_ALU0: return FU_ALU;
      FU_ALU1: return FU_ALU;
      FU_MEM0: return FU_MEM;
      default: return FU_ALU;
    endcase
  endfunction

endpackage

// File: rtl/fu_busy_timer.sv
// Occupancy countdown for one functional unit; done is high in the last busy cycle.
module fu_busy_timer
  import fu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic [TAG_W-1:0] tag
);

  logic [CNT_W-1:0] cnt;

  // A squash beats a load so that a flushed cycle never leaves a live timer behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tag <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
      tag <= load_tag;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/fu_allocator.sv
// Grants one issuing instruction per cycle to a free, type-compatible FU and
// drives the FU table's full next-state ready vector every cycle.
module fu_allocator
  import fu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FU-1:0]       table_in,
  output logic [NUM_FU-1:0]       update_out,
  input  logic                    issue_valid,
  input  logic                    issue_type,
  input  logic [TAG_W-1:0]        issue_tag,
  output logic                    issue_grant,
  output logic [1:0]              issue_fu,
  input  logic                    flush,
  output logic [NUM_FU-1:0]       done_valid,
  output logic [NUM_FU*TAG_W-1:0] done_tag,
  output logic                    err
);

  fu_type_e          req_type;
  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] load;
  logic [NUM_FU-1:0] busy;
  logic [NUM_FU-1:0] done;
  logic [TAG_W-1:0]  tag_q [NUM_FU];
  logic [CNT_W-1:0]  load_val;
  logic              grant_any;
  logic [1:0]        grant_idx;

  assign req_type = fu_type_e'(issue_type);
  assign load_val = (req_type == FU_MEM) ? CNT_W'(MEM_LAT) : CNT_W'(ALU_LAT);

  always_comb begin
    eligible = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      eligible[f] = table_in[f] && (fu_type_of(f) == req_type);
    end
  end

  // Scanning downwards lets the lowest eligible index win.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    for (int f = NUM_FU - 1; f >= 0; f--) begin
      if (eligible[f]) begin
        grant_any = 1'b1;
        grant_idx = 2'(f);
      end
    end
  end

  assign issue_grant = issue_valid && !flush && !rst && grant_any;
  assign issue_fu    = issue_grant ? grant_idx : 2'd0;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
    assign load[f] = issue_grant && (grant_idx == 2'(f));

    fu_busy_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load[f]),
      .load_val (load_val),
      .load_tag (issue_tag),
      .clear    (flush),
      .busy     (busy[f]),
      .done     (done[f]),
      .tag      (tag_q[f])
    );

    assign done_tag[f*TAG_W +: TAG_W] = tag_q[f];
  end

  assign done_valid = done & ~{NUM_FU{flush | rst}};

  always_comb begin
    update_out = table_in;
    for (int f = 0; f < NUM_FU; f++) begin
      if (rst || flush) begin
        update_out[f] = 1'b1;
      end else if (load[f]) begin
        update_out[f] = 1'b0;
      end else if (done_valid[f]) begin
        update_out[f] = 1'b1;
      end
    end
  end

  // A table bit reading free while its timer still has more than one cycle to run is a bookkeeping fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (|(table_in & busy & ~done)) begin
      err <= 1'b1;
    end
  end

endmodule
